// File: rtl/character_drawer_if.sv
// Pixel-stream bundle between the movement FSM, the drawer and the VGA adapter.
// The master side drives the position code and watches the pixel stream.
interface character_drawer_if;
  logic [3:0] CurrState;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] Colour;
  logic       Plot;
  logic       DoneDrawing;

  modport master (
    output CurrState,
    input  X, Y, Colour, Plot, DoneDrawing
  );

  modport slave (
    input  CurrState,
    output X, Y, Colour, Plot, DoneDrawing
  );
endinterface

// File: rtl/character_drawer.sv
// Character sprite renderer: erases the sprite at its old lane position,
// then redraws it at the position given by the movement FSM code.
module character_drawer #(
  parameter int       X_ORIGIN      = 16,
  parameter int       Y_ORIGIN      = 100,
  parameter int       LANE_PITCH    = 40,
  parameter int       SPRITE_W      = 8,
  parameter int       SPRITE_H      = 8,
  parameter logic [2:0] SPRITE_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input logic Clock,
  input logic Reset,
  character_drawer_if.slave bus
);

  localparam int PXW  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int PYW  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int HALF = LANE_PITCH / 2;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ERASE,
    DRAW
  } state_t;

  state_t state_q, state_d;

  logic [3:0]     drawn_q, drawn_d;
  logic [3:0]     target_q, target_d;
  logic [2:0]     old_h_q, old_h_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [7:0]     x_q, x_d;
  logic [6:0]     y_q, y_d;
  logic [2:0]     col_q, col_d;
  logic           plot_q, plot_d;
  logic           done_q, done_d;

  logic           last_px;
  logic           last_px_py;
  logic [2:0]     scan_h;

  // Transition codes map to odd half-lane slots between two positions.
  function automatic logic [2:0] half_idx(input logic [3:0] c);
    logic [2:0] h;
    case (c)
      4'd0:          h = 3'd0;
      4'd4, 4'd5:    h = 3'd1;
      4'd1:          h = 3'd2;
      4'd6, 4'd7:    h = 3'd3;
      4'd2:          h = 3'd4;
      4'd8, 4'd9:    h = 3'd5;
      4'd3:          h = 3'd6;
      default:       h = 3'd0;
    endcase
    return h;
  endfunction

  function automatic logic code_ok(input logic [3:0] c);
    return c < 4'd10;
  endfunction

  function automatic logic [7:0] base_x(input logic [2:0] h);
    return 8'(X_ORIGIN + int'(h) * HALF);
  endfunction

  assign last_px    = (px_q == PXW'(SPRITE_W - 1));
  assign last_px_py = last_px && (py_q == PYW'(SPRITE_H - 1));

  // Lane the current scan targets: home on init, old spot on erase.
  always_comb begin
    scan_h = 3'd0;
    unique case (state_q)
      INIT:  scan_h = 3'd0;
      ERASE: scan_h = old_h_q;
      DRAW:  scan_h = half_idx(target_q);
      IDLE:  scan_h = 3'd0;
    endcase
  end

  // Next-state, scan counters and registered pixel outputs.
  always_comb begin
    state_d  = state_q;
    drawn_d  = drawn_q;
    target_d = target_q;
    old_h_d  = old_h_q;
    px_d     = px_q;
    py_d     = py_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    done_d   = done_q;

    if (state_q == IDLE) begin
      done_d = 1'b1;
      if (code_ok(bus.CurrState) && bus.CurrState != drawn_q) begin
        target_d = bus.CurrState;
        old_h_d  = half_idx(drawn_q);
        done_d   = 1'b0;
        state_d  = ERASE;
      end
    end else begin
      plot_d = 1'b1;
      done_d = 1'b0;
      x_d    = base_x(scan_h) + 8'(px_q);
      y_d    = 7'(Y_ORIGIN) + 7'(py_q);
      col_d  = (state_q == ERASE) ? BG_COLOUR : SPRITE_COLOUR;

      if (last_px) begin
        px_d = '0;
        py_d = last_px_py ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end

      if (last_px_py) begin
        if (state_q == ERASE) begin
          state_d = DRAW;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (state_q == DRAW) drawn_d = target_q;
        end
      end
    end
  end

  // State and output registers; reset aborts any scan immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= INIT;
      drawn_q  <= 4'd0;
      target_q <= 4'd0;
      old_h_q  <= 3'd0;
      px_q     <= '0;
      py_q     <= '0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      col_q    <= 3'd0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drawn_q  <= drawn_d;
      target_q <= target_d;
      old_h_q  <= old_h_d;
      px_q     <= px_d;
      py_q     <= py_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign bus.X           = x_q;
  assign bus.Y           = y_q;
  assign bus.Colour      = col_q;
  assign bus.Plot        = plot_q;
  assign bus.DoneDrawing = done_q;

endmodule

// File: tb/tb_character_drawer.sv
// Scoreboard bench for the character sprite renderer.
// Expected pixels are queued as passes are requested and popped on Plot.
module tb_character_drawer;

  logic Clock;
  logic Reset;

  character_drawer_if bus();

  character_drawer dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t q[$];

  int vectors;
  int miscompares;
  logic [3:0] drawn_m;
  logic [2:0] hmap [0:15];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_pass(input logic [2:0] h, input logic [2:0] c);
    pix_t p;
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        p.x = 8'(16 + int'(h) * 20 + px);
        p.y = 7'(100 + py);
        p.c = c;
        q.push_back(p);
      end
    end
  endtask

  task automatic wait_done(input int start, output int cnt);
    cnt = start;
    do begin
      @(negedge Clock);
      if (bus.DoneDrawing !== 1'b1) cnt++;
    end while (bus.DoneDrawing !== 1'b1 && cnt < 2000);
    if (cnt >= 2000) check("done_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    @(negedge Clock);
    check({tag, "_drain"}, q.size(), 0);
    check({tag, "_plot0"}, bus.Plot, 0);
    check({tag, "_done1"}, bus.DoneDrawing, 1);
  endtask

  task automatic redraw(input logic [3:0] code, input string tag);
    int cnt;
    push_pass(hmap[drawn_m], 3'b000);
    push_pass(hmap[code], 3'b010);
    bus.CurrState = code;
    wait_done(0, cnt);
    check({tag, "_low"}, cnt, 128);
    drain(tag);
    drawn_m = code;
  endtask

  task automatic idle_hold(input logic [3:0] code, input string tag);
    int bad;
    bad = 0;
    bus.CurrState = code;
    repeat (200) begin
      @(negedge Clock);
      if (bus.Plot !== 1'b0 || bus.DoneDrawing !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_x"}, bus.X, 0);
    check({tag, "_y"}, bus.Y, 0);
    check({tag, "_col"}, bus.Colour, 0);
    check({tag, "_plot"}, bus.Plot, 0);
    check({tag, "_done"}, bus.DoneDrawing, 0);
  endtask

  // Pop and compare one expected pixel for every plotted cycle.
  always @(negedge Clock) begin
    pix_t e;
    if (bus.Plot === 1'b1) begin
      if (q.size() == 0) begin
        check("extra_plot", 1, 0);
      end else begin
        e = q.pop_front();
        check("pix_x", bus.X, e.x);
        check("pix_y", bus.Y, e.y);
        check("pix_col", bus.Colour, e.c);
      end
    end
  end

  initial begin
    int cnt;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) hmap[i] = 3'd0;
    hmap[0] = 3'd0; hmap[4] = 3'd1; hmap[5] = 3'd1;
    hmap[1] = 3'd2; hmap[6] = 3'd3; hmap[7] = 3'd3;
    hmap[2] = 3'd4; hmap[8] = 3'd5; hmap[9] = 3'd5;
    hmap[3] = 3'd6;
    drawn_m = 4'd0;

    Reset = 1'b0;
    bus.CurrState = 4'd0;
    repeat (3) @(negedge Clock);
    check_reset_outs("rst");

    push_pass(3'd0, 3'b010);
    Reset = 1'b1;
    wait_done(0, cnt);
    check("init_low", cnt, 63);
    drain("init");

    redraw(4'd1, "r0_1");
    redraw(4'd0, "r1_0");
    redraw(4'd4, "r0_t01");
    redraw(4'd1, "rt01_1");

    idle_hold(4'd12, "idle_invalid");
    idle_hold(4'd1, "idle_same");

    redraw(4'd0, "r1_0b");
    push_pass(3'd0, 3'b000);
    push_pass(3'd2, 3'b010);
    push_pass(3'd2, 3'b000);
    push_pass(3'd4, 3'b010);
    bus.CurrState = 4'd1;
    repeat (80) @(negedge Clock);
    check("mid_still_busy", bus.DoneDrawing, 0);
    bus.CurrState = 4'd2;
    wait_done(80, cnt);
    check("mid_first_low", cnt, 128);
    wait_done(0, cnt);
    check("mid_second_low", cnt, 128);
    drain("mid");
    drawn_m = 4'd2;

    push_pass(3'd4, 3'b000);
    bus.CurrState = 4'd0;
    repeat (31) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check_reset_outs("abort");
    q.delete();
    push_pass(3'd0, 3'b010);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    wait_done(0, cnt);
    check("reinit_low", cnt, 63);
    drain("reinit");
    drawn_m = 4'd0;

    redraw(4'd3, "r0_3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
